sbox_pipe: RTL and testbench

- Parametrised, programmable, multi-lane S-box lookup engine for the S-DES datapath and wider cipher variants.
- Each lane maps an IN_W-bit index to an OUT_W-bit value through its own run-time loadable table.
- All lanes share one valid/ready stream with a 2-register pipeline, backpressure support and a transfer counter.
- Replaces fixed combinational S-boxes in the round function so the key-schedule/round controller can load tables and stream data through.

---
 rtl/sbox_pipe.sv | 135 +++++++++++++
 tb/tb_sbox_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_pipe.sv
// Multi-lane programmable S-box lookup behind a 2-register valid/ready pipeline with a saturating transfer counter.
// Optional table write lock and error pulse when SBOX_PIPE_LOCK_EN is defined.
module sbox_pipe #(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 2,
    parameter int NUM_LANES = 2,
    parameter int CNT_W     = 16,
    localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES*IN_W-1:0]  in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_LANES*OUT_W-1:0] out_data,
    input  logic                       cfg_we,
    input  logic [LANE_W-1:0]          cfg_lane,
    input  logic [IN_W-1:0]            cfg_addr,
    input  logic [OUT_W-1:0]           cfg_data,
    output logic [CNT_W-1:0]           xfer_count
`ifdef SBOX_PIPE_LOCK_EN
    ,
    input  logic                       cfg_lock,
    output logic                       cfg_err
`endif
);

    localparam int DEPTH = 2 ** IN_W;

    logic [OUT_W-1:0]           tbl_q [NUM_LANES][DEPTH];
    logic                       a_vld_q, a_vld_d;
    logic [NUM_LANES*IN_W-1:0]  a_dat_q, a_dat_d;
    logic                       b_vld_q, b_vld_d;
    logic [NUM_LANES*OUT_W-1:0] b_dat_q, b_dat_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_LANES*OUT_W-1:0] lookup;
    logic                       adv_b, in_fire, a_move, out_fire;
    logic                       lane_ok, wr_en;

    assign adv_b    = !b_vld_q || out_ready;
    assign in_ready = !a_vld_q || adv_b;
    assign in_fire  = in_valid && in_ready;
    assign a_move   = a_vld_q && adv_b;
    assign out_fire = b_vld_q && out_ready;

    assign out_valid  = b_vld_q;
    assign out_data   = b_dat_q;
    assign xfer_count = cnt_q;

    // Table is read from registered state, so a same-edge write is not visible to this lookup.
    always_comb begin
        lookup = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lookup[i*OUT_W +: OUT_W] = tbl_q[i][a_dat_q[i*IN_W +: IN_W]];
        end
    end

    always_comb begin
        a_vld_d = a_vld_q;
        a_dat_d = a_dat_q;
        b_vld_d = b_vld_q;
        b_dat_d = b_dat_q;
        cnt_d   = cnt_q;
        if (in_fire) begin
            a_vld_d = 1'b1;
            a_dat_d = in_data;
        end else if (a_move) begin
            a_vld_d = 1'b0;
        end
        if (a_move) begin
            b_vld_d = 1'b1;
            b_dat_d = lookup;
        end else if (out_fire) begin
            b_vld_d = 1'b0;
        end
        if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q <= 1'b0;
            a_dat_q <= '0;
            b_vld_q <= 1'b0;
            b_dat_q <= '0;
            cnt_q   <= '0;
        end else begin
            a_vld_q <= a_vld_d;
            a_dat_q <= a_dat_d;
            b_vld_q <= b_vld_d;
            b_dat_q <= b_dat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lane_ok = ({1'b0, cfg_lane} < (LANE_W + 1)'(NUM_LANES));

`ifdef SBOX_PIPE_LOCK_EN
    logic lock_q, err_q;

    // Lock applies from the cycle after cfg_lock, so a coincident write still lands.
    assign wr_en   = cfg_we && lane_ok && !lock_q;
    assign cfg_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (cfg_lock) begin
                lock_q <= 1'b1;
            end
            err_q <= cfg_we && lock_q;
        end
    end
`else
    assign wr_en = cfg_we && lane_ok;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    tbl_q[i][j] <= '0;
                end
            end
        end else if (wr_en) begin
            tbl_q[cfg_lane][cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_sbox_pipe.sv
// Directed checks of sbox_pipe with the S-DES S1 table loaded into both lanes.
module tb_sbox_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        cfg_we;
    logic [0:0]  cfg_lane;
    logic [3:0]  cfg_addr;
    logic [1:0]  cfg_data;
    logic [15:0] xfer_count;
`ifdef SBOX_PIPE_LOCK_EN
    logic        cfg_lock;
    logic        cfg_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [1:0] s1_tbl [16] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b11, 2'b11,
                                2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11};

    always #5 clk = ~clk;

    sbox_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_lane   (cfg_lane),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .xfer_count (xfer_count)
`ifdef SBOX_PIPE_LOCK_EN
        ,
        .cfg_lock   (cfg_lock),
        .cfg_err    (cfg_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        cfg_we = 1'b0;
        cfg_lane = 1'b0;
        cfg_addr = 4'h0;
        cfg_data = 2'b00;
`ifdef SBOX_PIPE_LOCK_EN
        cfg_lock = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_tables();
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < 16; a++) begin
                cfg_we = 1'b1;
                cfg_lane = l[0:0];
                cfg_addr = a[3:0];
                cfg_data = s1_tbl[a];
                tick();
            end
        end
        cfg_we = 1'b0;
    endtask

    // Pushes one word through an otherwise idle pipe and returns the looked-up value.
    task automatic lookup_word(input logic [7:0] d, output logic [3:0] r, output logic v);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
        tick();
        r = out_data;
        v = out_valid;
        tick();
    endtask

    task automatic test_reset();
        logic [3:0] r;
        logic v;
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (xfer_count !== 16'd0) begin bad++; $display("FAIL reset_xfer got=%0d exp=0", xfer_count); end
        total++; if (out_data !== 4'b0000) begin bad++; $display("FAIL reset_out_data got=%b exp=0000", out_data); end
        lookup_word(8'h00, r, v);
        total++; if (v !== 1'b1 || r !== 4'b0000) begin bad++; $display("FAIL empty_lookup got=%b/%b exp=1/0000", v, r); end
    endtask

    task automatic test_stream();
        do_reset();
        load_tables();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h68;
        tick();
        in_data = 8'h19;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 4'b1111) begin bad++; $display("FAIL stream_w0 got=%b/%b exp=1/1111", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 4'b1010) begin bad++; $display("FAIL stream_w1 got=%b/%b exp=1/1010", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
        total++; if (xfer_count !== 16'd2) begin bad++; $display("FAIL stream_count got=%0d exp=2", xfer_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_tables();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h68;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_second_ready got=%b exp=1", in_ready); end
        in_data = 8'h19;
        tick();
        in_data = 8'hFA;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b1 || out_data !== 4'b1111) begin bad++; $display("FAIL bp_hold0 got=%b/%b exp=1/1111", out_valid, out_data); end
        tick();
        tick();
        total++; if (in_ready !== 1'b0 || out_data !== 4'b1111 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_hold1 got=rdy%b/%b/%b exp=rdy0/1/1111", in_ready, out_valid, out_data); end
        total++; if (xfer_count !== 16'd0) begin bad++; $display("FAIL bp_count_hold got=%0d exp=0", xfer_count); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_comb_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 4'b1010) begin bad++; $display("FAIL bp_rel1 got=%b/%b exp=1/1010", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 4'b1100) begin bad++; $display("FAIL bp_rel2 got=%b/%b exp=1/1100", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
        total++; if (xfer_count !== 16'd3) begin bad++; $display("FAIL bp_count got=%0d exp=3", xfer_count); end
    endtask

    task automatic test_write_collision();
        logic [3:0] r;
        logic v;
        do_reset();
        load_tables();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h68;
        tick();
        in_valid = 1'b0;
        cfg_we = 1'b1;
        cfg_lane = 1'b1;
        cfg_addr = 4'h6;
        cfg_data = 2'b00;
        tick();
        cfg_we = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 4'b1111) begin bad++; $display("FAIL wr_same_edge got=%b/%b exp=1/1111", out_valid, out_data); end
        tick();
        lookup_word(8'h68, r, v);
        total++; if (v !== 1'b1 || r !== 4'b0011) begin bad++; $display("FAIL wr_after got=%b/%b exp=1/0011", v, r); end
    endtask

    task automatic test_reset_midstream();
        logic [3:0] r;
        logic v;
        do_reset();
        load_tables();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h68;
        tick();
        in_data = 8'h19;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || xfer_count !== 16'd0) begin bad++; $display("FAIL mid_rst got=%b/%0d exp=0/0", out_valid, xfer_count); end
        rst = 1'b0;
        out_ready = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", in_ready); end
        tick();
        tick();
        tick();
        total++; if (out_valid !== 1'b0 || xfer_count !== 16'd0) begin bad++; $display("FAIL mid_rst_stale got=%b/%0d exp=0/0", out_valid, xfer_count); end
        lookup_word(8'h68, r, v);
        total++; if (v !== 1'b1 || r !== 4'b0000) begin bad++; $display("FAIL mid_rst_tbl got=%b/%b exp=1/0000", v, r); end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h00;
        repeat (100) tick();
        total++; if (xfer_count !== 16'd98) begin bad++; $display("FAIL sat_mid got=%0d exp=98", xfer_count); end
        repeat (65500) tick();
        in_valid = 1'b0;
        tick();
        tick();
        total++; if (xfer_count !== 16'hFFFF) begin bad++; $display("FAIL sat_cap got=%0d exp=65535", xfer_count); end
    endtask

`ifdef SBOX_PIPE_LOCK_EN
    task automatic test_lock();
        logic [3:0] r;
        logic v;
        do_reset();
        cfg_lock = 1'b1;
        tick();
        cfg_lock = 1'b0;
        cfg_we = 1'b1;
        cfg_lane = 1'b0;
        cfg_addr = 4'h0;
        cfg_data = 2'b11;
        tick();
        cfg_we = 1'b0;
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL lock_err got=%b exp=1", cfg_err); end
        tick();
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL lock_err_pulse got=%b exp=0", cfg_err); end
        lookup_word(8'h00, r, v);
        total++; if (r !== 4'b0000) begin bad++; $display("FAIL lock_blocked got=%b exp=0000", r); end
        do_reset();
        cfg_we = 1'b1;
        cfg_lane = 1'b0;
        cfg_addr = 4'h0;
        cfg_data = 2'b11;
        tick();
        cfg_we = 1'b0;
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL unlock_err got=%b exp=0", cfg_err); end
        lookup_word(8'h00, r, v);
        total++; if (r !== 4'b0011) begin bad++; $display("FAIL unlock_wr got=%b exp=0011", r); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_write_collision();
        test_reset_midstream();
`ifdef SBOX_PIPE_LOCK_EN
        test_lock();
`endif
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
